// File: rtl/index_sequencer.sv
// -----------------------------------------------------------------------------
// index_sequencer
//
// Generates the 3-bit index that feeds the 3-to-8 LED decoder. The index
// advances either on a prescaled tick (auto mode) or on a debounced push-button
// rising edge (manual mode), in either direction. It can also be loaded
// synchronously. A one-cycle wrap pulse marks the cycle in which the index
// shows a wrapped value.
//
// Ports
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high; clears all state
//   io_en        in   1 = advancing allowed; 0 = hold index and prescaler
//   io_mode      in   0 = auto (prescaler tick), 1 = manual (button)
//   io_dir       in   0 = count up, 1 = count down
//   io_step      in   raw asynchronous push-button level
//   io_load      in   synchronous load strobe (highest priority)
//   io_load_val  in   [2:0] value loaded on io_load
//   io_out       out  [2:0] current index, registered
//   io_wrap      out  one-cycle registered pulse on 7->0 (up) or 0->7 (down)
// -----------------------------------------------------------------------------
module index_sequencer #(
   parameter int TICK_DIV = 4,  // clock cycles per auto advance, >= 2
   parameter int DEBOUNCE = 4   // cycles a new level must persist, >= 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       io_en,
   input  logic       io_mode,
   input  logic       io_dir,
   input  logic       io_step,
   input  logic       io_load,
   input  logic [2:0] io_load_val,
   output logic [2:0] io_out,
   output logic       io_wrap
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE - 1);

   // ---------------------------------------------------------------------------
   // Prescaler
   // ---------------------------------------------------------------------------
   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   assign tick = (pre_q == PRE_MAX) & io_en & ~io_mode;

   always_comb begin
      pre_d = pre_q;
      // Manual mode and load both restart the count, so the first auto advance
      // after either always comes a full TICK_DIV edges later.
      if (io_mode || io_load) begin
         pre_d = '0;
      end else if (io_en) begin
         pre_d = tick ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Button path: 2-flop synchronizer, debouncer, rising-edge detect
   // ---------------------------------------------------------------------------
   logic          s1_q, s2_q;
   logic          deb_q, deb_d;
   logic          deb_prev_q;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          press;

   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      if (s2_q == deb_q) begin
         cnt_d = '0;
      end else if (cnt_q == DEB_MAX) begin
         deb_d = s2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1_q       <= 1'b0;
         s2_q       <= 1'b0;
         deb_q      <= 1'b0;
         deb_prev_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         s1_q       <= io_step;
         s2_q       <= s1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         cnt_q      <= cnt_d;
      end
   end

   // The debouncer keeps running in auto mode; a press seen there is simply
   // dropped rather than held for a later switch to manual.
   assign press = deb_q & ~deb_prev_q;

   // ---------------------------------------------------------------------------
   // Index register and wrap pulse
   // ---------------------------------------------------------------------------
   logic [2:0] out_q, out_d;
   logic       wrap_q, wrap_d;
   logic       advance;

   assign advance = tick | (press & io_mode & io_en);

   always_comb begin
      out_d  = out_q;
      wrap_d = 1'b0;
      if (io_load) begin
         out_d = io_load_val;
      end else if (advance) begin
         if (io_dir) begin
            out_d  = out_q - 3'd1;
            wrap_d = (out_q == 3'd0);
         end else begin
            out_d  = out_q + 3'd1;
            wrap_d = (out_q == 3'd7);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_q  <= 3'd0;
         wrap_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         wrap_q <= wrap_d;
      end
   end

   assign io_out  = out_q;
   assign io_wrap = wrap_q;

endmodule

// File: tb/tb_index_sequencer.sv
// -----------------------------------------------------------------------------
// tb_index_sequencer
//
// Directed bench for index_sequencer with TICK_DIV = 4, DEBOUNCE = 4.
// Inputs change only between edges; outputs are sampled 1 ns after a rising
// edge. "edge N" below counts rising edges after the most recent reset release.
// -----------------------------------------------------------------------------
module tb_index_sequencer;

   logic       clock;
   logic       reset;
   logic       io_en;
   logic       io_mode;
   logic       io_dir;
   logic       io_step;
   logic       io_load;
   logic [2:0] io_load_val;
   logic [2:0] io_out;
   logic       io_wrap;

   int vec_cnt = 0;
   int err_cnt = 0;

   index_sequencer #(
      .TICK_DIV (4),
      .DEBOUNCE (4)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .io_en       (io_en),
      .io_mode     (io_mode),
      .io_dir      (io_dir),
      .io_step     (io_step),
      .io_load     (io_load),
      .io_load_val (io_load_val),
      .io_out      (io_out),
      .io_wrap     (io_wrap)
   );

   // clock: rising edges at 5, 15, 25, ...
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Called 1 ns after an edge: pulses reset between edges, checks that the
   // index clears before any further clock edge, and releases before the next.
   task automatic async_reset(input string tag);
      #2 reset = 1'b1;
      #1 check({tag, "_out"}, {5'd0, io_out}, 8'd0);
      check({tag, "_wrap"}, {7'd0, io_wrap}, 8'd0);
      #2 reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      io_en       = 1'b1;
      io_mode     = 1'b0;
      io_dir      = 1'b0;
      io_step     = 1'b0;
      io_load     = 1'b0;
      io_load_val = 3'd0;

      // Reset state
      #1;
      check("rst_out", {5'd0, io_out}, 8'd0);
      check("rst_wrap", {7'd0, io_wrap}, 8'd0);
      #1 reset = 1'b0;   // released at t=2, before edge 1

      // ---- Auto count up -------------------------------------------------
      step(3);
      check("auto_e3", {5'd0, io_out}, 8'd0);
      step(1);
      check("auto_e4", {5'd0, io_out}, 8'd1);
      step(4);
      check("auto_e8", {5'd0, io_out}, 8'd2);
      step(23);
      check("auto_e31_out", {5'd0, io_out}, 8'd7);
      check("auto_e31_wrap", {7'd0, io_wrap}, 8'd0);
      step(1);
      check("auto_e32_out", {5'd0, io_out}, 8'd0);
      check("auto_e32_wrap", {7'd0, io_wrap}, 8'd1);
      step(1);
      check("auto_e33_out", {5'd0, io_out}, 8'd0);
      check("auto_e33_wrap", {7'd0, io_wrap}, 8'd0);

      // ---- Auto count down through the wrap ------------------------------
      io_dir = 1'b1;     // prescaler is 1 here; next tick at edge 36
      step(3);
      check("down_e36_out", {5'd0, io_out}, 8'd7);
      check("down_e36_wrap", {7'd0, io_wrap}, 8'd1);
      step(4);
      check("down_e40_out", {5'd0, io_out}, 8'd6);
      check("down_e40_wrap", {7'd0, io_wrap}, 8'd0);
      step(4);
      check("down_e44_out", {5'd0, io_out}, 8'd5);

      // ---- Load on the same edge as a tick -------------------------------
      step(3);                       // edge 47, prescaler at 3
      io_load     = 1'b1;
      io_load_val = 3'd3;
      step(1);                       // edge 48: tick and load together
      io_load = 1'b0;
      check("load_out", {5'd0, io_out}, 8'd3);
      check("load_wrap", {7'd0, io_wrap}, 8'd0);
      step(3);
      check("load_e51", {5'd0, io_out}, 8'd3);
      step(1);
      check("load_e52", {5'd0, io_out}, 8'd2);

      // ---- Enable low holds index and prescaler --------------------------
      step(2);                       // edge 54, prescaler at 2
      io_en = 1'b0;
      step(10);
      check("hold_out", {5'd0, io_out}, 8'd2);
      io_en = 1'b1;
      step(1);                       // prescaler 2 -> 3
      check("hold_resume_e1", {5'd0, io_out}, 8'd2);
      step(1);                       // tick
      check("hold_resume_e2", {5'd0, io_out}, 8'd1);

      // ---- Asynchronous reset between edges ------------------------------
      async_reset("areset1");

      // ---- Manual: long hold gives exactly one advance -------------------
      io_mode = 1'b1;
      io_dir  = 1'b0;
      io_step = 1'b1;                // high before edge 1
      step(6);
      check("man_e6", {5'd0, io_out}, 8'd0);
      step(1);
      check("man_e7", {5'd0, io_out}, 8'd1);
      step(13);
      check("man_held", {5'd0, io_out}, 8'd1);
      check("man_held_wrap", {7'd0, io_wrap}, 8'd0);
      io_step = 1'b0;
      step(10);
      check("man_release", {5'd0, io_out}, 8'd1);
      io_step = 1'b1;
      step(7);
      check("man_press2", {5'd0, io_out}, 8'd2);
      io_step = 1'b0;
      step(10);

      // ---- Manual: short glitches rejected --------------------------------
      async_reset("areset2");
      for (int i = 0; i < 8; i++) begin
         io_step = 1'b1;
         step(1);
         check("glitch_wrap_h", {7'd0, io_wrap}, 8'd0);
         step(1);
         io_step = 1'b0;
         step(2);
         check("glitch_out", {5'd0, io_out}, 8'd0);
      end
      step(8);
      check("glitch_final", {5'd0, io_out}, 8'd0);

      // ---- Press in auto mode is discarded --------------------------------
      io_mode = 1'b0;
      io_en   = 1'b0;                // keep the prescaler out of the picture
      io_step = 1'b1;
      step(10);
      io_step = 1'b0;
      step(10);
      io_mode = 1'b1;
      io_en   = 1'b1;
      step(5);
      check("auto_press_drop", {5'd0, io_out}, 8'd0);

      // ---- Manual -> auto starts the prescaler from 0 ---------------------
      io_mode = 1'b0;
      step(3);
      check("m2a_e3", {5'd0, io_out}, 8'd0);
      step(1);
      check("m2a_e4", {5'd0, io_out}, 8'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   // Bound on total run time in case the stimulus stalls.
   initial begin
      #100000;
      $display("FAIL timeout: run did not finish, %0d vectors, %0d miscompares", vec_cnt, err_cnt);
      $fatal(1);
   end

endmodule
